// File: rtl/spi_burst_ctrl_pkg.sv
// Shared state encoding and default timing constants for the SPI burst sequencer.
// Pure declarations: no latency, no backpressure.
package spi_burst_ctrl_pkg;

  localparam int DEF_LEN_WIDTH    = 8;
  localparam int DEF_CS_SETUP_CYC = 10;
  localparam int DEF_BYTE_GAP_CYC = 4;
  localparam int DEF_CS_HOLD_CYC  = 10;
  localparam int DEF_DLY_WIDTH    = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_FETCH   = 3'd2;
  localparam logic [2:0] ST_XFER    = 3'd3;
  localparam logic [2:0] ST_CAPTURE = 3'd4;
  localparam logic [2:0] ST_GAP     = 3'd5;
  localparam logic [2:0] ST_HOLD    = 3'd6;
  localparam logic [2:0] ST_DONE    = 3'd7;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    SETUP   = ST_SETUP,
    FETCH   = ST_FETCH,
    XFER    = ST_XFER,
    CAPTURE = ST_CAPTURE,
    GAP     = ST_GAP,
    HOLD    = ST_HOLD,
    DONE    = ST_DONE
  } state_t;

endpackage

// File: rtl/spi_burst_ctrl_delay_cnt.sv
// Loadable down-counter; done is high on the last cycle of a loaded delay (load 0 or 1 = 1 cycle).
// Latency: load takes effect next cycle; no backpressure.
module spi_delay_cnt
  import spi_burst_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_DLY_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt <= WIDTH'(1));

endmodule

// File: rtl/spi_burst_ctrl.sv
// Burst sequencer: drives cs_n, feeds bytes to the SPI master one work_en/work_end at a time.
// Latency/byte: FETCH + master time + CAPTURE + gap; TX stalls hold cs_n low, RX has no backpressure.
module spi_burst_ctrl
  import spi_burst_ctrl_pkg::*;
#(
  parameter int LEN_WIDTH    = DEF_LEN_WIDTH,
  parameter int CS_SETUP_CYC = DEF_CS_SETUP_CYC,
  parameter int BYTE_GAP_CYC = DEF_BYTE_GAP_CYC,
  parameter int CS_HOLD_CYC  = DEF_CS_HOLD_CYC,
  parameter int DLY_WIDTH    = DEF_DLY_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [LEN_WIDTH-1:0] i_len,
  input  logic [7:0]           i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic [7:0]           o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_cs_n,
  output logic                 om_work_en,
  input  logic                 im_work_end,
  output logic [7:0]           om_data_bus,
  input  logic [7:0]           im_data_bus
);

  state_t                 state, state_nxt;
  logic [LEN_WIDTH-1:0]   remaining;
  logic                   dly_load, dly_done;
  logic [DLY_WIDTH-1:0]   dly_val;
  logic                   cs_clr, cs_set, en_set, en_clr, rem_load, rem_dec, tx_rdy;

  spi_delay_cnt #(.WIDTH(DLY_WIDTH)) u_dly (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (dly_load),
    .load_val (dly_val),
    .done     (dly_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dly_load  = 1'b0;
    dly_val   = '0;
    tx_rdy    = 1'b0;
    cs_clr    = 1'b0;
    cs_set    = 1'b0;
    en_set    = 1'b0;
    en_clr    = 1'b0;
    rem_load  = 1'b0;
    rem_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          // Zero-length bursts skip straight to DONE so remaining can never underflow.
          if (i_len != '0) begin
            state_nxt = SETUP;
            rem_load  = 1'b1;
            cs_clr    = 1'b1;
            dly_load  = 1'b1;
            dly_val   = DLY_WIDTH'(CS_SETUP_CYC);
          end else begin
            state_nxt = DONE;
          end
        end
      end
      SETUP:   if (dly_done) state_nxt = FETCH;
      FETCH: begin
        tx_rdy = 1'b1;
        if (i_tx_valid) begin
          en_set    = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (im_work_end) begin
          en_clr    = 1'b1;
          rem_dec   = 1'b1;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        dly_load = 1'b1;
        if (remaining != '0) begin
          state_nxt = GAP;
          dly_val   = DLY_WIDTH'(BYTE_GAP_CYC);
        end else begin
          state_nxt = HOLD;
          dly_val   = DLY_WIDTH'(CS_HOLD_CYC);
        end
      end
      GAP:     if (dly_done) state_nxt = FETCH;
      HOLD: begin
        if (dly_done) begin
          cs_set    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cs_n      <= 1'b1;
      om_work_en  <= 1'b0;
      om_data_bus <= '0;
      o_rx_data   <= '0;
      o_rx_valid  <= 1'b0;
      o_done      <= 1'b0;
      remaining   <= '0;
    end else begin
      o_rx_valid <= (state == CAPTURE);
      o_done     <= (state == DONE);
      if (state == CAPTURE) o_rx_data <= im_data_bus;
      if (cs_clr)      o_cs_n <= 1'b0;
      else if (cs_set) o_cs_n <= 1'b1;
      // om_data_bus is deliberately left holding the last byte between transfers.
      if (en_set) begin
        om_work_en  <= 1'b1;
        om_data_bus <= i_tx_data;
      end else if (en_clr) begin
        om_work_en <= 1'b0;
      end
      if (rem_load)     remaining <= i_len;
      else if (rem_dec) remaining <= remaining - 1'b1;
    end
  end

  assign o_tx_ready = tx_rdy;
  assign o_busy     = (state != IDLE);

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Bench for spi_burst_ctrl: behavioural loopback master, stalling TX feeder and
// event monitor; each scenario task compares observed events with expectations from the timing rules.
module tb_spi_burst_ctrl;

  localparam int LW      = 8;
  localparam int SETUP_C = 10;
  localparam int GAP_C   = 4;
  localparam int HOLD_C  = 10;
  localparam int DW      = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_start = 1'b0;
  logic [LW-1:0] i_len = '0;
  logic [7:0]    i_tx_data = '0;
  logic          i_tx_valid = 1'b0;
  logic          o_tx_ready;
  logic [7:0]    o_rx_data;
  logic          o_rx_valid, o_busy, o_done, o_cs_n, om_work_en;
  logic          im_work_end = 1'b0;
  logic [7:0]    om_data_bus;
  logic [7:0]    im_data_bus = '0;

  spi_burst_ctrl #(
    .LEN_WIDTH(LW), .CS_SETUP_CYC(SETUP_C), .BYTE_GAP_CYC(GAP_C),
    .CS_HOLD_CYC(HOLD_C), .DLY_WIDTH(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_len(i_len),
    .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready),
    .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .o_busy(o_busy), .o_done(o_done),
    .o_cs_n(o_cs_n), .om_work_en(om_work_en), .im_work_end(im_work_end),
    .om_data_bus(om_data_bus), .im_data_bus(im_data_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- behavioural loopback master ----------------
  int         m_dur_min = 8, m_dur_max = 8;
  logic       m_busy = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_byte = '0;
  int         wend_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy      = 1'b0;
      im_work_end = 1'b0;
    end else begin
      im_work_end = 1'b0;
      if (m_busy) begin
        if (m_cnt == 0) begin
          im_work_end = 1'b1;
          im_data_bus = m_byte;
          m_busy      = 1'b0;
          wend_q.push_back(cyc);
        end else begin
          m_cnt--;
        end
      end else if (om_work_en) begin
        m_busy      = 1'b1;
        m_cnt       = $urandom_range(m_dur_max, m_dur_min);
        m_byte      = om_data_bus;
        im_data_bus = 8'($urandom);
      end
    end
  end

  // ---------------- TX feeder with per-byte stalls ----------------
  logic [7:0] tx_q[$];
  int         stall_q[$];
  logic       hs = 1'b0;
  logic       stall_loaded = 1'b0;
  int         stall_left = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hs           = 1'b0;
      i_tx_valid   = 1'b0;
      stall_loaded = 1'b0;
    end else begin
      if (hs) begin
        void'(tx_q.pop_front());
        void'(stall_q.pop_front());
        stall_loaded = 1'b0;
        hs           = 1'b0;
      end
      i_tx_valid = 1'b0;
      if (tx_q.size() > 0) begin
        if (!stall_loaded) begin
          stall_left   = stall_q[0];
          stall_loaded = 1'b1;
        end
        if (stall_left > 0) stall_left--;
        else begin
          i_tx_valid = 1'b1;
          i_tx_data  = tx_q[0];
        end
      end
      hs = i_tx_valid && o_tx_ready;
    end
  end

  // ---------------- event monitor ----------------
  logic [7:0] rx_q[$];
  logic [7:0] bus_q[$];
  int en_rise_q[$];
  int done_cnt, done_cyc, en_cnt, cs_fall_cnt, cs_rise_cnt, cs_fall_cyc, cs_rise_cyc;
  int rdy_cnt, first_rdy_cyc, rxv_cyc, viol;
  logic prev_en = 1'b0, prev_cs = 1'b1;

  always @(negedge clk) begin
    if (o_rx_valid) begin
      rx_q.push_back(o_rx_data);
      rxv_cyc = cyc;
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (om_work_en && !prev_en) begin
      en_cnt++;
      en_rise_q.push_back(cyc);
      bus_q.push_back(om_data_bus);
    end
    if (!o_cs_n && prev_cs) begin cs_fall_cnt++; cs_fall_cyc = cyc; end
    if (o_cs_n && !prev_cs) begin cs_rise_cnt++; cs_rise_cyc = cyc; end
    if (o_tx_ready) begin
      rdy_cnt++;
      if (first_rdy_cyc < 0) first_rdy_cyc = cyc;
    end
    if ((o_tx_ready && om_work_en) || (om_work_en && o_cs_n)) viol++;
    prev_en = om_work_en;
    prev_cs = o_cs_n;
  end

  task automatic clear_mon();
    @(posedge clk);
    rx_q.delete(); bus_q.delete(); en_rise_q.delete(); wend_q.delete();
    done_cnt = 0; done_cyc = -1; en_cnt = 0; cs_fall_cnt = 0; cs_rise_cnt = 0;
    cs_fall_cyc = -1; cs_rise_cyc = -1; rdy_cnt = 0; first_rdy_cyc = -1;
    rxv_cyc = -1; viol = 0;
  endtask

  task automatic start_burst(input int len);
    @(negedge clk);
    i_start   = 1'b1;
    i_len     = LW'(len);
    start_cyc = cyc;
    @(negedge clk);
    i_start = 1'b0;
    i_len   = LW'($urandom);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done_cnt == 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_cnt == 0) begin
      failures++;
      $display("FAIL done_timeout: o_done not seen within %0d cycles (required 1 pulse)", bound);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_cs_n, om_work_en, o_tx_ready, o_rx_valid, o_done, o_busy} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b required 100000",
               {o_cs_n, om_work_en, o_tx_ready, o_rx_valid, o_done, o_busy});
    end
    checks++;
    if (om_data_bus !== 8'h00) begin
      failures++; $display("FAIL reset_data_bus: got %h required 00", om_data_bus);
    end
    checks++;
    if (o_rx_data !== 8'h00) begin
      failures++; $display("FAIL reset_rx_data: got %h required 00", o_rx_data);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_cs_n !== 1'b1) begin
      failures++; $display("FAIL reset_release: busy=%b cs_n=%b required 0/1", o_busy, o_cs_n);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] exp[3] = '{8'hA5, 8'h3C, 8'hFF};
    clear_mon();
    m_dur_min = 8; m_dur_max = 8;
    for (int i = 0; i < 3; i++) begin tx_q.push_back(exp[i]); stall_q.push_back(0); end
    start_burst(3);
    wait_done(400);
    repeat (4) @(negedge clk);
    checks++;
    if (rx_q.size() != 3) begin
      failures++; $display("FAIL loop_rx_count: got %0d required 3", rx_q.size());
    end
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp[i]) begin
        failures++; $display("FAIL loop_rx_byte%0d: got %h required %h", i, rx_q[i], exp[i]);
      end
    end
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL loop_done: got %0d required 1", done_cnt); end
    checks++;
    if (en_cnt != 3) begin failures++; $display("FAIL loop_work_en: got %0d required 3", en_cnt); end
    checks++;
    if (cs_fall_cyc != start_cyc + 1 || cs_fall_cnt != 1 || cs_rise_cnt != 1) begin
      failures++;
      $display("FAIL loop_cs: fall_cyc=%0d falls=%0d rises=%0d required %0d/1/1",
               cs_fall_cyc, cs_fall_cnt, cs_rise_cnt, start_cyc + 1);
    end
    checks++;
    if (viol != 0) begin failures++; $display("FAIL loop_protocol: got %0d violations required 0", viol); end
  endtask

  task automatic test_tx_stall();
    logic [7:0] exp[2];
    clear_mon();
    for (int i = 0; i < 2; i++) begin
      exp[i] = 8'($urandom);
      tx_q.push_back(exp[i]);
    end
    stall_q.push_back(0); stall_q.push_back(50);
    start_burst(2);
    wait_done(400);
    repeat (4) @(negedge clk);
    checks++;
    if (rx_q.size() != 2 || rx_q[0] !== exp[0] || rx_q[1] !== exp[1]) begin
      failures++; $display("FAIL stall_rx: got %0d bytes required 2 (%h %h)", rx_q.size(), exp[0], exp[1]);
    end
    checks++;
    if (cs_fall_cnt != 1 || cs_rise_cnt != 1) begin
      failures++; $display("FAIL stall_cs: falls=%0d rises=%0d required 1/1", cs_fall_cnt, cs_rise_cnt);
    end
    checks++;
    if (rdy_cnt < 30) begin failures++; $display("FAIL stall_wait: ready cycles %0d required >=30", rdy_cnt); end
    checks++;
    if (en_cnt != 2 || viol != 0) begin
      failures++; $display("FAIL stall_work_en: periods=%0d viol=%0d required 2/0", en_cnt, viol);
    end
  endtask

  task automatic test_zero_len();
    clear_mon();
    start_burst(0);
    wait_done(20);
    repeat (20) @(negedge clk);
    checks++;
    if (done_cyc - start_cyc != 2) begin
      failures++; $display("FAIL zero_done_latency: got %0d required 2", done_cyc - start_cyc);
    end
    checks++;
    if (cs_fall_cnt != 0 || rdy_cnt != 0 || en_cnt != 0) begin
      failures++;
      $display("FAIL zero_no_activity: cs_falls=%0d ready=%0d work_en=%0d required 0/0/0",
               cs_fall_cnt, rdy_cnt, en_cnt);
    end
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL zero_done_count: got %0d required 1", done_cnt); end
  endtask

  task automatic test_busy_start();
    logic [7:0] exp[2];
    int n = 0;
    clear_mon();
    for (int i = 0; i < 2; i++) begin
      exp[i] = 8'($urandom);
      tx_q.push_back(exp[i]); stall_q.push_back(0);
    end
    start_burst(2);
    while (en_cnt == 0 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    i_start = 1'b1; i_len = LW'(5);
    @(negedge clk);
    i_start = 1'b0;
    wait_done(400);
    repeat (40) @(negedge clk);
    checks++;
    if (done_cnt != 1 || cs_fall_cnt != 1 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_start_ignored: done=%0d cs_falls=%0d busy=%b required 1/1/0",
               done_cnt, cs_fall_cnt, o_busy);
    end
    checks++;
    if (rx_q.size() != 2 || rx_q[0] !== exp[0] || rx_q[1] !== exp[1] || en_cnt != 2) begin
      failures++; $display("FAIL busy_start_bytes: got %0d rx, %0d work_en required 2/2", rx_q.size(), en_cnt);
    end
  endtask

  task automatic test_timing();
    clear_mon();
    m_dur_min = 8; m_dur_max = 8;
    for (int i = 0; i < 3; i++) begin tx_q.push_back(8'($urandom)); stall_q.push_back(0); end
    start_burst(3);
    wait_done(400);
    repeat (4) @(negedge clk);
    checks++;
    if (first_rdy_cyc - cs_fall_cyc != SETUP_C) begin
      failures++; $display("FAIL timing_setup: got %0d required %0d", first_rdy_cyc - cs_fall_cyc, SETUP_C);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (en_rise_q.size() < 3 || wend_q.size() < 2) begin
        failures++; $display("FAIL timing_gap%0d: got %0d work_en rises required 3", k, en_rise_q.size());
      end else if (en_rise_q[k+1] - (wend_q[k] + 1) != 1 + GAP_C + 1) begin
        failures++;
        $display("FAIL timing_gap%0d: got %0d required %0d", k, en_rise_q[k+1] - (wend_q[k] + 1), 1 + GAP_C + 1);
      end
    end
    checks++;
    if (cs_rise_cyc - rxv_cyc != HOLD_C) begin
      failures++; $display("FAIL timing_hold: got %0d required %0d", cs_rise_cyc - rxv_cyc, HOLD_C);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      logic [7:0] exp[$];
      int len;
      int bad;
      clear_mon();
      m_dur_min = 0; m_dur_max = 10;
      len = $urandom_range(6, 1);
      for (int i = 0; i < len; i++) begin
        exp.push_back(8'($urandom));
        tx_q.push_back(exp[i]);
        stall_q.push_back(($urandom_range(3, 0) == 0) ? $urandom_range(12, 1) : 0);
      end
      start_burst(len);
      wait_done(1500);
      repeat (4) @(negedge clk);
      bad = 0;
      for (int i = 0; i < len; i++)
        if (i >= rx_q.size() || rx_q[i] !== exp[i] || i >= bus_q.size() || bus_q[i] !== exp[i]) bad++;
      checks++;
      if (bad != 0 || rx_q.size() != len) begin
        failures++; $display("FAIL rand%0d_data: %0d bad of %0d, rx=%0d", it, bad, len, rx_q.size());
      end
      checks++;
      if (done_cnt != 1 || en_cnt != len || viol != 0 || cs_rise_cnt != 1) begin
        failures++;
        $display("FAIL rand%0d_ctrl: done=%0d work_en=%0d viol=%0d cs_rises=%0d required 1/%0d/0/1",
                 it, done_cnt, en_cnt, viol, cs_rise_cnt, len);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int n = 0;
    clear_mon();
    m_dur_min = 10; m_dur_max = 10;
    for (int i = 0; i < 4; i++) begin tx_q.push_back(8'($urandom)); stall_q.push_back(0); end
    start_burst(4);
    while (en_cnt < 2 && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++;
    if (om_work_en !== 1'b1) begin failures++; $display("FAIL rstmid_in_xfer: work_en=%b required 1", om_work_en); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o_cs_n !== 1'b1 || om_work_en !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async: cs_n=%b work_en=%b busy=%b required 1/0/0", o_cs_n, om_work_en, o_busy);
    end
    repeat (3) @(negedge clk);
    tx_q.delete(); stall_q.delete();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt != 0 || rx_q.size() != 1) begin
      failures++; $display("FAIL rstmid_no_partial: done=%0d rx=%0d required 0/1", done_cnt, rx_q.size());
    end
    clear_mon();
    b = 8'($urandom);
    tx_q.push_back(b); stall_q.push_back(0);
    start_burst(1);
    wait_done(300);
    repeat (4) @(negedge clk);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== b || done_cnt != 1) begin
      failures++; $display("FAIL rstmid_recover: rx=%0d done=%0d required 1 byte %h, 1 done", rx_q.size(), done_cnt, b);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_tx_stall();
    test_zero_len();
    test_busy_start();
    test_timing();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
